// File: rtl/fwd_adapter.sv
// Packet forwarder: reads a buffered packet from P3 word by word and streams it out as AXI-Stream.
// Defining FWD_ADAPTER_PESS_EN inserts a two-entry registered skid slice in front of the m_* outputs.
module fwd_adapter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PLEN_WIDTH = 32,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fwd_rdy,
  input  logic [PLEN_WIDTH-1:0]   fwd_plen,
  output logic                    fwd_rdy_ack,
  output logic [ADDR_WIDTH-1:0]   fwd_addr,
  output logic                    fwd_rd_en,
  input  logic [DATA_WIDTH-1:0]   fwd_rd_data,
  output logic                    fwd_done,
  input  logic                    fwd_done_ack,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready
);
  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NW_W       = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W      = PLEN_WIDTH + 1;
  localparam int unsigned MAX_NW     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;

  // Word count and last-beat byte enables for the packet offered on fwd_plen.
  logic [LEN_W-1:0]      nw_raw;
  logic [PLEN_WIDTH-1:0] rem;
  logic                  clamp;
  logic [NW_W-1:0]       nw_in;
  logic [BYTES-1:0]      keep_in;

  assign nw_raw  = (LEN_W'(fwd_plen) + LEN_W'(BYTES - 1)) / LEN_W'(BYTES);
  assign rem     = fwd_plen % PLEN_WIDTH'(BYTES);
  assign clamp   = nw_raw > LEN_W'(MAX_NW);
  assign nw_in   = clamp ? NW_W'(MAX_NW) : NW_W'(nw_raw);
  assign keep_in = (clamp || rem == '0) ? '1 : ~({BYTES{1'b1}} << rem);

  logic [NW_W-1:0]       nw;
  logic [NW_W-1:0]       cnt_iss;
  logic [NW_W-1:0]       cnt_beat;
  logic [BYTES-1:0]      last_keep;
  logic [CNT_W-1:0]      resv;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W-1:0]      resv_left;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [RD_LAT-1:0]     rd_vld;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic issue;
  logic latch;
  logic fifo_valid;
  logic head_last;
  logic last_xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // resv counts words issued but not yet popped, so the FIFO can never overflow.
  assign push       = rd_vld[RD_LAT-1];
  assign fifo_valid = fifo_cnt != '0;
  assign head_last  = cnt_beat == nw - NW_W'(1);
  assign resv_left  = resv - CNT_W'(pop);
  assign latch      = (state == IDLE) && fwd_rdy;
  assign issue      = (latch && fwd_plen != '0) ||
                      ((state == READ) && (cnt_iss < nw) && (resv_left < CNT_W'(FIFO_DEPTH)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fwd_rdy_ack <= 1'b0;
      fwd_rd_en   <= 1'b0;
      fwd_addr    <= '0;
      fwd_done    <= 1'b0;
      nw          <= '0;
      cnt_iss     <= '0;
      cnt_beat    <= '0;
      last_keep   <= '0;
      resv        <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_vld      <= '0;
    end else begin
      fwd_rdy_ack <= latch;
      fwd_rd_en   <= issue;
      rd_vld      <= (rd_vld << 1) | RD_LAT'(fwd_rd_en);
      fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      resv        <= resv_left + CNT_W'(issue);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (issue) fwd_addr <= latch ? '0 : cnt_iss[ADDR_WIDTH-1:0];

      if (latch) begin
        nw        <= nw_in;
        last_keep <= keep_in;
        cnt_beat  <= '0;
        cnt_iss   <= NW_W'(issue);
      end else begin
        if (issue) cnt_iss  <= cnt_iss + NW_W'(1);
        if (pop)   cnt_beat <= cnt_beat + NW_W'(1);
      end

      case (state)
        IDLE: begin
          if (fwd_rdy) begin
            if (fwd_plen == '0) begin
              state    <= DONE;
              fwd_done <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (cnt_iss == nw) state <= DRAIN;
        end
        DRAIN: begin
          if (last_xfer) begin
            state    <= DONE;
            fwd_done <= 1'b1;
          end
        end
        DONE: begin
          if (fwd_done_ack) begin
            state    <= IDLE;
            fwd_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fwd_rd_data;
  end

`ifdef FWD_ADAPTER_PESS_EN
  logic [DATA_WIDTH-1:0] sl_data [2];
  logic [BYTES-1:0]      sl_keep [2];
  logic [1:0]            sl_last;
  logic                  sl_wr;
  logic                  sl_rd;
  logic [1:0]            sl_cnt;
  logic                  sl_pop;

  assign pop    = fifo_valid && (sl_cnt != 2'd2);
  assign sl_pop = m_tvalid && m_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sl_data <= '{default: '0};
      sl_keep <= '{default: '0};
      sl_last <= '0;
      sl_wr   <= 1'b0;
      sl_rd   <= 1'b0;
      sl_cnt  <= '0;
    end else begin
      if (pop) begin
        sl_data[sl_wr] <= fifo_mem[rd_ptr];
        sl_keep[sl_wr] <= head_last ? last_keep : '1;
        sl_last[sl_wr] <= head_last;
        sl_wr          <= ~sl_wr;
      end
      if (sl_pop) sl_rd <= ~sl_rd;
      sl_cnt <= sl_cnt + 2'(pop) - 2'(sl_pop);
    end
  end

  assign m_tvalid = sl_cnt != '0;
  assign m_tdata  = m_tvalid ? sl_data[sl_rd] : '0;
  assign m_tkeep  = m_tvalid ? sl_keep[sl_rd] : '0;
  assign m_tlast  = m_tvalid && sl_last[sl_rd];
`else
  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = fifo_valid;
  assign m_tdata  = fifo_valid ? fifo_mem[rd_ptr] : '0;
  assign m_tkeep  = fifo_valid ? (head_last ? last_keep : '1) : '0;
  assign m_tlast  = fifo_valid && head_last;
`endif

  assign last_xfer = m_tvalid && m_tready && m_tlast;

endmodule

// File: tb/tb_fwd_adapter.sv
// Self-checking bench for fwd_adapter: random packets against a byte-level packet model.
`timescale 1ns/1ps
module tb_fwd_adapter;
  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 64;
  localparam int unsigned PW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned NB   = DW / 8;
  localparam int unsigned MAXB = 1 << AW;
`ifdef FWD_ADAPTER_PESS_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fwd_rdy;
  logic [PW-1:0] fwd_plen;
  logic          fwd_rdy_ack;
  logic [AW-1:0] fwd_addr;
  logic          fwd_rd_en;
  logic [DW-1:0] fwd_rd_data;
  logic          fwd_done;
  logic          fwd_done_ack;
  logic [DW-1:0] m_tdata;
  logic [NB-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .fwd_rdy(fwd_rdy), .fwd_plen(fwd_plen), .fwd_rdy_ack(fwd_rdy_ack),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_rd_data(fwd_rd_data), .fwd_done(fwd_done),
    .fwd_done_ack(fwd_done_ack), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  // P3 packet buffer with a fixed read latency; unrequested cycles return junk.
  logic [DW-1:0] mem [MAXB];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fwd_rd_en ? mem[fwd_addr] : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fwd_rd_data = pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;
  beat_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy_ack"}, 64'(fwd_rdy_ack), 0);
    check({tag, "_rd_en"},   64'(fwd_rd_en), 0);
    check({tag, "_done"},    64'(fwd_done), 0);
    check({tag, "_tvalid"},  64'(m_tvalid), 0);
    check({tag, "_tlast"},   64'(m_tlast), 0);
    check({tag, "_addr"},    64'(fwd_addr), 0);
    check({tag, "_tdata"},   64'(m_tdata), 0);
    check({tag, "_tkeep"},   64'(m_tkeep), 0);
  endtask

  // mode 0: ready always 1; mode 1: random ready plus ignored rdy/done_ack noise; mode 2: ready 1,0,0,1 then 1.
  task automatic run_pkt(input int plen, input int mode, input int abort_beat, input int hold);
    int    nw, nrd, nbeat, vcnt, first_val, last_acc, cyc, bytes_left, nbytes;
    bit    clamp, r, held, aborted;
    beat_t e;
    logic [DW-1:0] hd;
    logic [NB-1:0] hk;
    logic          hl;

    for (int i = 0; i < int'(MAXB); i++) mem[i] = {$urandom, $urandom};
    exp_q.delete();
    nw = (plen + int'(NB) - 1) / int'(NB);
    clamp = nw > int'(MAXB);
    if (clamp) nw = int'(MAXB);
    bytes_left = plen;
    for (int i = 0; i < nw; i++) begin
      nbytes = (clamp || bytes_left >= int'(NB)) ? int'(NB) : bytes_left;
      bytes_left -= nbytes;
      e.d = mem[i];
      e.k = NB'((64'd1 << nbytes) - 64'd1);
      e.l = (i == nw - 1);
      exp_q.push_back(e);
    end

    nrd = 0; nbeat = 0; vcnt = 0; first_val = -1; last_acc = -1;
    held = 0; aborted = 0; hd = '0; hk = '0; hl = 1'b0;
    fwd_plen = PW'(plen);
    fwd_rdy  = 1'b1;
    @(negedge clk);
    check("rdy_ack", 64'(fwd_rdy_ack), 1);
    fwd_rdy  = 1'b0;
    fwd_plen = $urandom;

    for (cyc = 0; cyc < 6000; cyc++) begin
      if (cyc == 0) check("first_rd_en", 64'(fwd_rd_en), 64'(plen != 0));
      else          check("ack_pulse", 64'(fwd_rdy_ack), 0);
      if (fwd_rd_en) begin
        check("rd_addr", 64'(fwd_addr), 64'(nrd));
        nrd++;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = !(vcnt == 1 || vcnt == 2);
      endcase
      if (m_tvalid) begin
        if (first_val < 0) first_val = cyc;
        if (held) begin
          check("stall_data", m_tdata, hd);
          check("stall_keep", 64'(m_tkeep), 64'(hk));
          check("stall_last", 64'(m_tlast), 64'(hl));
        end
        if (abort_beat >= 0 && nbeat == abort_beat) begin
          aborted = 1;
          break;
        end
        vcnt++;
        if (r) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(nbeat + 1), 64'(nw));
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_tdata, e.d);
            check("beat_keep", 64'(m_tkeep), 64'(e.k));
            check("beat_last", 64'(m_tlast), 64'(e.l));
          end
          nbeat++;
          last_acc = cyc;
          held = 0;
        end else begin
          held = 1;
          hd = m_tdata;
          hk = m_tkeep;
          hl = m_tlast;
        end
      end
      m_tready = r;
      if (fwd_done) break;
      if (mode == 1) begin
        fwd_rdy      = 1'($urandom_range(0, 1));
        fwd_done_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    fwd_rdy      = 1'b0;
    fwd_done_ack = 1'b0;

    if (aborted) begin
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      rst = 1'b1;
      m_tready = 1'b1;
      for (int i = 0; i < int'(LAT) + 4; i++) begin
        @(negedge clk);
        check("post_rst_tvalid", 64'(m_tvalid), 0);
        check("post_rst_rd_en", 64'(fwd_rd_en), 0);
      end
      return;
    end

    check("done", 64'(fwd_done), 1);
    check("beats", 64'(nbeat), 64'(nw));
    check("reads", 64'(nrd), 64'(nw));
    if (plen != 0) begin
      check("latency", 64'(first_val), 64'(LAT + 1 + EXTRA));
      check("done_after_last", 64'(cyc), 64'(last_acc + 1));
      if (mode == 0) check("throughput", 64'(last_acc - first_val), 64'(nw - 1));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_hold", 64'(fwd_done), 1);
      check("idle_tvalid", 64'(m_tvalid), 0);
    end
    fwd_done_ack = 1'b1;
    @(negedge clk);
    check("done_drop", 64'(fwd_done), 0);
    fwd_done_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int plen;
    rst          = 1'b0;
    fwd_rdy      = 1'b0;
    fwd_plen     = '0;
    fwd_done_ack = 1'b0;
    m_tready     = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_pkt(20, 0, -1, 2);
    run_pkt(16, 2, -1, 2);
    run_pkt(0, 0, -1, 5);
    run_pkt(4096, 0, -1, 1);
    run_pkt(4100, 1, -1, 1);
    run_pkt(80, 0, 3, 0);
    run_pkt(80, 0, -1, 0);
    run_pkt(1, 1, -1, 0);
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 7))
        0:       plen = 0;
        1:       plen = int'($urandom_range(3000, 6000));
        default: plen = int'($urandom_range(1, 300));
      endcase
      run_pkt(plen, int'($urandom_range(0, 1)), -1, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
